// File: rtl/fetch_pkg.sv
// Shared fetch-path types: bundle layout and the slot-mask helper.
package fetch_pkg;
    localparam int PC_W     = 8;
    localparam int INST_W   = 13;
    localparam int FETCH_W  = 3;
    localparam int FQ_DEPTH = 4;

    typedef struct packed {
        logic [PC_W-1:0]                pc;
        logic [FETCH_W-1:0][INST_W-1:0] inst;
        logic [FETCH_W-1:0]             mask;
    } fetch_bundle_t;

    // A slot is live only while pc+k still addresses memory; the carry-out marks the wrap.
    function automatic logic [FETCH_W-1:0] slot_mask(input logic [PC_W-1:0] pc);
        logic [FETCH_W-1:0] m;
        logic [PC_W:0]      a;
        m = '0;
        for (int k = 0; k < FETCH_W; k++) begin
            a    = {1'b0, pc} + (PC_W+1)'(k);
            m[k] = ~a[PC_W];
        end
        return m;
    endfunction
endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of fetch bundles with push/pop/flush; depth must be a power of two.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  fetch_bundle_t din_i,
    output fetch_bundle_t dout_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_bundle_t    mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[tail_q] <= din_i;
                tail_q        <= tail_q + 1'b1;
            end
            if (pop_i) head_q <= head_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign dout_o  = mem_q[head_q];
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
endmodule

// File: rtl/inst_fetch.sv
// Fetch unit: PC register, bundle capture with wrap masking, queue to decode.
// FETCH_BYPASS_EN: when the queue is empty the live bundle is presented to decode directly.
module inst_fetch #(
    parameter int PC_W     = fetch_pkg::PC_W,
    parameter int INST_W   = fetch_pkg::INST_W,
    parameter int FETCH_W  = fetch_pkg::FETCH_W,
    parameter int FQ_DEPTH = fetch_pkg::FQ_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic [PC_W-1:0]           pc,
    input  logic [INST_W*FETCH_W-1:0] inst,
    input  logic                      redirect_valid,
    input  logic [PC_W-1:0]           redirect_pc,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [PC_W-1:0]           out_pc,
    output logic [INST_W*FETCH_W-1:0] out_inst,
    output logic [FETCH_W-1:0]        out_mask
);
    import fetch_pkg::*;

    logic [PC_W-1:0]    pc_q, pc_d;
    logic [FETCH_W-1:0] mask;
    fetch_bundle_t      fetch_b, head_b;
    logic               q_full, q_empty, q_push, q_pop;
    logic               enq, deq, bypass;

    assign mask = slot_mask(pc_q);

    always_comb begin
        fetch_b      = '0;
        fetch_b.pc   = pc_q;
        fetch_b.mask = mask;
        for (int k = 0; k < FETCH_W; k++)
            fetch_b.inst[k] = mask[k] ? inst[k*INST_W +: INST_W] : '0;
    end

`ifdef FETCH_BYPASS_EN
    assign bypass = q_empty && !redirect_valid;
`else
    assign bypass = 1'b0;
`endif

    assign out_valid = bypass || !q_empty;
    assign deq       = out_valid && out_ready;
    assign enq       = !redirect_valid && (!q_full || deq);
    // A bypassed bundle taken by decode never occupies a queue slot.
    assign q_push    = enq && !(bypass && out_ready);
    assign q_pop     = deq && !bypass && !redirect_valid;

    assign pc_d = redirect_valid ? redirect_pc
                : enq            ? pc_q + PC_W'(FETCH_W)
                :                  pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_q <= '0;
        else        pc_q <= pc_d;
    end

    assign pc = pc_q;

    fetch_queue #(.DEPTH(FQ_DEPTH)) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (q_push),
        .pop_i   (q_pop),
        .flush_i (redirect_valid),
        .din_i   (fetch_b),
        .dout_o  (head_b),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    assign out_pc   = bypass ? fetch_b.pc   : head_b.pc;
    assign out_inst = bypass ? fetch_b.inst : head_b.inst;
    assign out_mask = bypass ? fetch_b.mask : head_b.mask;
endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: memory holds mem[i]=i; expected bundles queue up as they are fetched.
module tb_inst_fetch;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  pc;
    logic [38:0] inst;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_pc;
    logic [38:0] out_inst;
    logic [2:0]  out_mask;

    always #5 clk = ~clk;

    inst_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc             (pc),
        .inst           (inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_mask       (out_mask)
    );

    always_comb begin
        inst = '0;
        for (int k = 0; k < 3; k++) inst[k*13 +: 13] = 13'(8'(pc + 8'(k)));
    end

    typedef struct {
        logic [7:0]  pc;
        logic [38:0] inst;
        logic [2:0]  mask;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] mpc;
    int         n_checks = 0;
    int         n_errors = 0;
    int         n_deq    = 0;
    int         n0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic exp_t predict(input logic [7:0] p);
        exp_t e;
        int   s;
        e.pc   = p;
        e.inst = '0;
        e.mask = '0;
        for (int k = 0; k < 3; k++) begin
            s = int'(p) + k;
            if (s <= 255) begin
                e.mask[k]          = 1'b1;
                e.inst[k*13 +: 13] = 13'(s);
            end
        end
        return e;
    endfunction

    // Called at a negedge with this cycle's inputs already driven.
    task automatic tick();
        exp_t e;
        logic deq_m;
        chk("pc", 64'(pc), 64'(mpc));
        chk("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
        deq_m = (exp_q.size() > 0) && out_ready;
        if (deq_m) begin
            e = exp_q.pop_front();
            chk("out_pc", 64'(out_pc), 64'(e.pc));
            chk("out_inst", 64'(out_inst), 64'(e.inst));
            chk("out_mask", 64'(out_mask), 64'(e.mask));
            n_deq++;
        end
        if (redirect_valid) begin
            exp_q.delete();
            mpc = redirect_pc;
        end else if (exp_q.size() < 4) begin
            exp_q.push_back(predict(mpc));
            mpc = mpc + 8'd3;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b1;
        mpc            = '0;
        repeat (2) @(negedge clk);
        chk("rst_pc", 64'(pc), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_out_pc", 64'(out_pc), 64'd0);
        chk("rst_out_inst", 64'(out_inst), 64'd0);
        chk("rst_out_mask", 64'(out_mask), 64'd0);
        rst_n = 1'b1;

        repeat (6) tick();

        // Restart at 0 and stall decode: four bundles fill the queue, pc parks at 12.
        redirect_valid = 1'b1; redirect_pc = 8'd0; out_ready = 1'b0;
        tick();
        redirect_valid = 1'b0;
        repeat (10) tick();
        chk("held_pc", 64'(pc), 64'd12);
        chk("held_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        n0 = n_deq;
        repeat (5) tick();
        chk("drain_cnt", 64'(n_deq - n0), 64'd5);
        repeat (6) tick();
        chk("full_tput", 64'(n_deq - n0), 64'd11);

        // Redirect to 40 with three bundles queued.
        redirect_valid = 1'b1; redirect_pc = 8'd100; out_ready = 1'b0;
        tick();
        redirect_valid = 1'b0;
        repeat (3) tick();
        redirect_valid = 1'b1; redirect_pc = 8'd40;
        tick();
        redirect_valid = 1'b0;
        chk("redir_pc", 64'(pc), 64'd40);
        chk("redir_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        tick();
        chk("redir_out_pc", 64'(out_pc), 64'd40);
        repeat (3) tick();

        // Top-of-memory wrap.
        redirect_valid = 1'b1; redirect_pc = 8'd254;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("wrap_pc", 64'(pc), 64'd1);
        chk("wrap_out_pc", 64'(out_pc), 64'd254);
        chk("wrap_mask", 64'(out_mask), 64'h3);
        chk("wrap_slot2", 64'(out_inst[38:26]), 64'd0);
        repeat (4) tick();

        // Asynchronous reset with a partly filled queue.
        out_ready = 1'b0;
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pc", 64'(pc), 64'd0);
        chk("arst_valid", 64'(out_valid), 64'd0);
        exp_q.delete();
        mpc = '0;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (6) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/inst_fetch.md
# inst_fetch

Front-end fetch unit and the requesting end of the 3-wide instruction-memory read port. It owns the PC, drives it to the instruction memory every cycle, and captures the combinationally returned 3-instruction bundle. Bundles are buffered in a small fetch queue and handed to decode through a valid/ready handshake. Branch/exception redirects flush the queue and restart fetch.

## Interface
Parameters:
- PC_W, 8, PC and memory index width
- INST_W, 13, instruction width
- FETCH_W, 3, instructions per bundle
- FQ_DEPTH, 4, fetch-queue depth in bundles (power of two, ≥2)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- pc  out  PC_W  read address to instruction memory
- inst  in  INST_W×FETCH_W  bundle returned combinationally for `pc`; inst[k] = mem[pc+k]
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  PC_W  restart address
- out_valid  out  1  bundle available to decode
- out_ready  in  1  decode accepts bundle
- out_pc  out  PC_W  PC of slot 0 of the head bundle
- out_inst  out  INST_W×FETCH_W  head bundle instructions
- out_mask  out  FETCH_W  per-slot valid bits of head bundle

## Operation
- State: fetch PC register, queue storage, head/tail pointers, count (0..FQ_DEPTH).
- `pc` output = fetch PC register, directly (no combinational path from other inputs).
- Enqueue condition `enq` = !redirect_valid && (count < FQ_DEPTH || deq). `deq` = out_valid && out_ready.
- On enq: write {pc, inst, mask} at tail; fetch PC ← (pc + FETCH_W) mod 2^PC_W.
- mask[k] = 1 iff pc + k ≤ 2^PC_W − 1 (computed at PC_W+1 bits); slots past the top of memory are masked off, their inst forced to 0. Next fetch wraps to pc + FETCH_W − 2^PC_W.
- Full queue with no deq: fetch PC holds, no write.
- Dequeue: out_* show head entry; on deq head advances.
- Redirect (highest priority): count ← 0, head = tail ← 0, fetch PC ← redirect_pc; no enqueue and no dequeue effect that cycle (a concurrent deq still counts as consumed by decode but the entry is discarded anyway); out_valid = 0 the following cycle unless bypass applies.
- Simultaneous enq and deq when full: allowed, count unchanged.
- Reset: fetch PC = 0, count = 0, pointers = 0, out_valid = 0, out_pc = 0, out_inst = 0, out_mask = 0.

## Timing
- Memory read is zero-latency; bundle captured on the same edge that advances the PC.
- Fetch-to-decode latency: 1 cycle (bundle fetched in cycle N visible on out_* in N+1).
- Steady state: one bundle per cycle when out_ready held high.
- out_valid depends only on registered state (no combinational path from out_ready or inst), except under FETCH_BYPASS_EN.
- redirect_valid in cycle N → pc = redirect_pc in N+1 → its bundle on out_* in N+2.

## Configuration
- FETCH_BYPASS_EN defined: when count = 0 and !redirect_valid, out_valid = 1 and out_* driven combinationally from the current pc/inst; if out_ready, the bundle is consumed without being written (PC still advances). Latency 0 cycles when empty.
- Undefined: all bundles pass through the queue; latency exactly 1 cycle; out_* fully registered.

## Structure
- Package fetch_pkg: PC_W, INST_W, FETCH_W constants; typedef fetch_bundle_t {pc, inst[FETCH_W], mask}.
- Sub-module fetch_queue: circular FIFO of fetch_bundle_t with push/pop/flush, full/empty, count; inst_fetch holds the PC logic, mask generation and bypass.

## Test plan
- Reset, memory preloaded mem[i]=i, out_ready=1 → pc 0,3,6…; first out_valid one cycle after reset release with out_pc=0, out_inst={2,1,0}, out_mask=3'b111.
- out_ready=0 for 10 cycles → exactly 4 bundles queued (pc 0..9), pc held at 12; release → bundles 0,3,6,9,12 in order, none lost or duplicated.
- redirect_valid with redirect_pc=40 while queue holds 3 bundles → next cycle pc=40, out_valid=0; following cycle out_pc=40.
- redirect_pc=254 → bundle out_pc=254, out_mask=3'b011, out_inst[2]=0; next bundle out_pc=1.
- Full queue with out_ready=1 every cycle after fill → enq and deq same cycle, count stays 4, throughput 1/cycle.
- Assert rst_n low mid-stream with queue non-empty → out_valid=0 and pc=0 immediately (asynchronous), fetch restarts at 0 after release.
